// File: rtl/hfe_pkg.sv
// rtl/hfe_pkg.sv - shared types and helpers for the header field extractor
package hfe_pkg;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_FILL = 1'b1
    } wr_state_e;

    // Width of the {slot, field, state} result record, for consumers slicing out_data.
    function automatic int rec_width(input int slot_w, input int data_w, input int state_w);
        return slot_w + data_w + state_w;
    endfunction

endpackage

// File: rtl/hfe_bank_ram.sv
// rtl/hfe_bank_ram.sv - simple dual-port RAM, one write port, one registered read port
module hfe_bank_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [1<<ADDR_W];

    // Read-before-write: a same-address read in the write cycle returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/head_field_extractor.sv
// rtl/head_field_extractor.sv - multi-slot header store with byte-offset field extraction
module head_field_extractor
    import hfe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SLOT_W  = 5,
    parameter int WORD_W  = 5,
    parameter int STATE_W = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   wr_valid,
    input  logic                                   wr_sop,
    input  logic                                   wr_last,
    input  logic [SLOT_W-1:0]                      wr_slot,
    input  logic [DATA_W-1:0]                      wr_data,
    output logic                                   wr_ovf,
    input  logic                                   rd_valid,
    input  logic [SLOT_W-1:0]                      rd_slot,
    input  logic [WORD_W+$clog2(DATA_W/8)-1:0]     rd_off,
    input  logic [STATE_W-1:0]                     rd_state,
    input  logic                                   rel_valid,
    input  logic [SLOT_W-1:0]                      rel_slot,
    output logic                                   out_valid,
    output logic [rec_width(SLOT_W, DATA_W, STATE_W)-1:0] out_data,
    output logic                                   out_err,
    output logic [(1<<SLOT_W)-1:0]                 slot_vld
);

    localparam int BYTES  = DATA_W / 8;
    localparam int BYTE_W = $clog2(BYTES);
    localparam int OFF_W  = WORD_W + BYTE_W;
    localparam int SLOTS  = 1 << SLOT_W;
    localparam int WORDS  = 1 << WORD_W;
    localparam int AW     = SLOT_W + WORD_W - 1;
    localparam int LEN_W  = WORD_W + 1;

    // ---------------- write FSM and slot tables ----------------
    wr_state_e         state, state_nx;
    logic [SLOT_W-1:0] cur_slot, cur_slot_nx;
    logic [WORD_W-1:0] cnt, cnt_nx;
    logic              we;
    logic [WORD_W-1:0] wword;
    logic [SLOT_W-1:0] wslot;
    logic              commit;
    logic [LEN_W-1:0]  commit_len;
    logic              clr;
    logic              drop;
    logic [LEN_W-1:0]  len [SLOTS];

    always_comb begin
        state_nx    = state;
        cur_slot_nx = cur_slot;
        cnt_nx      = cnt;
        we          = 1'b0;
        wword       = '0;
        wslot       = cur_slot;
        commit      = 1'b0;
        commit_len  = '0;
        clr         = 1'b0;
        drop        = 1'b0;
        if (wr_valid) begin
            if (wr_sop) begin
                we          = 1'b1;
                wslot       = wr_slot;
                clr         = 1'b1;
                cur_slot_nx = wr_slot;
                cnt_nx      = '0;
                state_nx    = WR_FILL;
                if (wr_last) begin
                    commit     = 1'b1;
                    commit_len = LEN_W'(1);
                    state_nx   = WR_IDLE;
                end
            end else if (state == WR_FILL) begin
                if (cnt == WORD_W'(WORDS - 1)) begin
                    drop = 1'b1;
                end else begin
                    we     = 1'b1;
                    wword  = cnt + 1'b1;
                    cnt_nx = cnt + 1'b1;
                end
                if (wr_last) begin
                    commit     = 1'b1;
                    commit_len = drop ? LEN_W'(WORDS) : {1'b0, cnt} + LEN_W'(2);
                    state_nx   = WR_IDLE;
                end
            end
        end
    end

    assign wr_ovf = drop;

    // Release is ignored for the slot being filled; commit overrides a same-cycle release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= WR_IDLE;
            cur_slot <= '0;
            cnt      <= '0;
            slot_vld <= '0;
            for (int s = 0; s < SLOTS; s++) begin
                len[s] <= '0;
            end
        end else begin
            state    <= state_nx;
            cur_slot <= cur_slot_nx;
            cnt      <= cnt_nx;
            if (rel_valid && !(state == WR_FILL && rel_slot == cur_slot)) begin
                slot_vld[rel_slot] <= 1'b0;
            end
            if (clr) begin
                slot_vld[wslot] <= 1'b0;
            end
            if (commit) begin
                slot_vld[wslot] <= 1'b1;
                len[wslot]      <= commit_len;
            end
        end
    end

    // ---------------- banked storage ----------------
    logic [AW-1:0]     waddr;
    logic [AW-1:0]     s1_ra0, s1_ra1;
    logic [DATA_W-1:0] q0, q1;

    assign waddr = {wslot, wword[WORD_W-1:1]};

    hfe_bank_ram #(.DATA_W(DATA_W), .ADDR_W(AW)) u_bank0 (
        .clk   (clk),
        .we    (we & ~wword[0]),
        .waddr (waddr),
        .wdata (wr_data),
        .raddr (s1_ra0),
        .rdata (q0)
    );

    hfe_bank_ram #(.DATA_W(DATA_W), .ADDR_W(AW)) u_bank1 (
        .clk   (clk),
        .we    (we & wword[0]),
        .waddr (waddr),
        .wdata (wr_data),
        .raddr (s1_ra1),
        .rdata (q1)
    );

    // ---------------- read pipeline ----------------
    logic [WORD_W-1:0]   rd_idx;
    logic [BYTE_W-1:0]   rd_b;
    logic [LEN_W-1:0]    rd_len;
    logic                rd_err;
    logic [WORD_W-2:0]   rd_half;

    assign rd_idx  = rd_off[OFF_W-1:BYTE_W];
    assign rd_b    = rd_off[BYTE_W-1:0];
    assign rd_len  = len[rd_slot];
    assign rd_half = rd_idx[WORD_W-1:1];
    assign rd_err  = !slot_vld[rd_slot]
                   || ({1'b0, rd_idx} >= rd_len)
                   || ((rd_b != '0) && (({1'b0, rd_idx} + LEN_W'(1)) >= rd_len));

    logic                s1_valid, s2_valid;
    logic [SLOT_W-1:0]   s1_slot, s2_slot;
    logic [STATE_W-1:0]  s1_state, s2_state;
    logic [BYTE_W-1:0]   s1_b, s2_b;
    logic                s1_odd, s2_odd;
    logic                s1_err, s2_err;

    // An odd start word sits in bank 1; its successor is the next even word in bank 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_slot  <= '0;
            s1_state <= '0;
            s1_b     <= '0;
            s1_odd   <= 1'b0;
            s1_err   <= 1'b0;
            s1_ra0   <= '0;
            s1_ra1   <= '0;
            s2_valid <= 1'b0;
            s2_slot  <= '0;
            s2_state <= '0;
            s2_b     <= '0;
            s2_odd   <= 1'b0;
            s2_err   <= 1'b0;
        end else begin
            s1_valid <= rd_valid;
            s1_slot  <= rd_slot;
            s1_state <= rd_state;
            s1_b     <= rd_b;
            s1_odd   <= rd_idx[0];
            s1_err   <= rd_err;
            s1_ra0   <= {rd_slot, rd_half + (WORD_W-1)'(rd_idx[0])};
            s1_ra1   <= {rd_slot, rd_half};
            s2_valid <= s1_valid;
            s2_slot  <= s1_slot;
            s2_state <= s1_state;
            s2_b     <= s1_b;
            s2_odd   <= s1_odd;
            s2_err   <= s1_err;
        end
    end

    // ---------------- aligner and output register ----------------
    logic [DATA_W-1:0]   hi_word, lo_word, field;
    logic [2*DATA_W-1:0] shifted;

    assign hi_word = s2_odd ? q1 : q0;
    assign lo_word = s2_odd ? q0 : q1;
    assign shifted = {hi_word, lo_word} << {s2_b, 3'b000};
    assign field   = shifted[2*DATA_W-1 -: DATA_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= s2_valid;
            out_err   <= s2_valid & s2_err;
            if (s2_valid) begin
                out_data <= {s2_slot, (s2_err ? {DATA_W{1'b0}} : field), s2_state};
            end else begin
                out_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_head_field_extractor.sv
// tb/tb_head_field_extractor.sv - scoreboard bench for head_field_extractor
module tb_head_field_extractor;

    logic        clk;
    logic        reset;
    logic        wr_valid, wr_sop, wr_last;
    logic [4:0]  wr_slot;
    logic [31:0] wr_data;
    logic        wr_ovf;
    logic        rd_valid;
    logic [4:0]  rd_slot;
    logic [6:0]  rd_off;
    logic [7:0]  rd_state;
    logic        rel_valid;
    logic [4:0]  rel_slot;
    logic        out_valid;
    logic [44:0] out_data;
    logic        out_err;
    logic [31:0] slot_vld;

    head_field_extractor dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_sop    (wr_sop),
        .wr_last   (wr_last),
        .wr_slot   (wr_slot),
        .wr_data   (wr_data),
        .wr_ovf    (wr_ovf),
        .rd_valid  (rd_valid),
        .rd_slot   (rd_slot),
        .rd_off    (rd_off),
        .rd_state  (rd_state),
        .rel_valid (rel_valid),
        .rel_slot  (rel_slot),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_err   (out_err),
        .slot_vld  (slot_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [4:0]  slot;
        logic [6:0]  off;
        logic [7:0]  state;
        logic [44:0] data;
        logic        err;
    } req_t;

    typedef struct {
        logic [44:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    req_t rq[$];
    exp_t sb[$];

    logic [31:0] mmem [32][32];
    logic [31:0] mvld;
    int          mlen [32];

    function automatic logic [31:0] model_field(input int slot, input int off);
        logic [31:0] f;
        int j;
        f = '0;
        for (int k = 0; k < 4; k++) begin
            j = off + k;
            f = {f[23:0], mmem[slot][j/4][31-8*(j%4) -: 8]};
        end
        return f;
    endfunction

    task automatic push_read_exp(input int slot, input int off, input int state,
                                 input logic [31:0] field, input logic err);
        req_t r;
        r.slot  = slot[4:0];
        r.off   = off[6:0];
        r.state = state[7:0];
        r.data  = {slot[4:0], field, state[7:0]};
        r.err   = err;
        rq.push_back(r);
    endtask

    task automatic push_read(input int slot, input int off, input int state);
        logic err;
        err = !mvld[slot] || (off + 4 > 4 * mlen[slot]);
        push_read_exp(slot, off, state, err ? 32'h0 : model_field(slot, off), err);
    endtask

    task automatic run_reads();
        int   budget;
        req_t r;
        exp_t e;
        budget = 300;
        while ((rq.size() != 0 || sb.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
            if (out_valid) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_out: got out_valid=1 data=%h, required no output", out_data);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.data) begin
                        miscompares++;
                        $display("FAIL out_data: got %h required %h", out_data, e.data);
                    end
                    vectors++;
                    if (out_err !== e.err) begin
                        miscompares++;
                        $display("FAIL out_err: got %b required %b", out_err, e.err);
                    end
                    vectors++;
                    if (cyc !== e.cyc + 3) begin
                        miscompares++;
                        $display("FAIL latency: got %0d cycles required 3", cyc - e.cyc);
                    end
                end
            end else if (sb.size() != 0 && cyc > sb[0].cyc + 3) begin
                vectors++;
                miscompares++;
                $display("FAIL missing_out: got no output required data=%h", sb[0].data);
                void'(sb.pop_front());
            end
            if (rq.size() != 0) begin
                r = rq.pop_front();
                rd_valid = 1'b1;
                rd_slot  = r.slot;
                rd_off   = r.off;
                rd_state = r.state;
                e.data   = r.data;
                e.err    = r.err;
                e.cyc    = cyc;
                sb.push_back(e);
            end else begin
                rd_valid = 1'b0;
            end
        end
        rd_valid = 1'b0;
        if (budget == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL read_timeout: got %0d outstanding required 0", rq.size() + sb.size());
            rq.delete();
            sb.delete();
        end
    endtask

    task automatic write_hdr(input int slot, input int n, input logic [31:0] base,
                             input logic [31:0] step, input logic do_rel);
        logic [31:0] d;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            d         = base + step * k;
            wr_valid  = 1'b1;
            wr_sop    = (k == 0);
            wr_last   = (k == n - 1);
            wr_slot   = slot[4:0];
            wr_data   = d;
            rel_valid = do_rel && (k == n - 1);
            rel_slot  = slot[4:0];
            if (k == 0) mvld[slot] = 1'b0;
            if (k < 32) mmem[slot][k] = d;
            #1;
            vectors++;
            if (wr_ovf !== (k >= 32)) begin
                miscompares++;
                $display("FAIL wr_ovf beat %0d: got %b required %b", k, wr_ovf, (k >= 32));
            end
        end
        @(negedge clk);
        wr_valid  = 1'b0;
        wr_sop    = 1'b0;
        wr_last   = 1'b0;
        rel_valid = 1'b0;
        mvld[slot] = 1'b1;
        mlen[slot] = (n > 32) ? 32 : n;
        vectors++;
        if (slot_vld !== mvld) begin
            miscompares++;
            $display("FAIL slot_vld after write: got %h required %h", slot_vld, mvld);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({out_valid, out_err, wr_ovf, out_data, slot_vld} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b e=%b o=%b d=%h s=%h required all 0",
                     out_valid, out_err, wr_ovf, out_data, slot_vld);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        write_hdr(3, 3, 32'h1122_3344, 32'h4444_4444, 1'b0);
        push_read_exp(3, 5, 8'h2A, 32'h6677_8899, 1'b0);
        run_reads();
    endtask

    task automatic test_back_to_back();
        push_read_exp(3, 0, 8'h01, 32'h1122_3344, 1'b0);
        push_read_exp(3, 4, 8'h02, 32'h5566_7788, 1'b0);
        push_read_exp(3, 8, 8'h03, 32'h99AA_BBCC, 1'b0);
        run_reads();
    endtask

    task automatic test_errors();
        push_read_exp(3, 9, 8'h11, 32'h0, 1'b1);
        push_read_exp(7, 0, 8'h12, 32'h0, 1'b1);
        push_read(3, 7, 8'h13);
        run_reads();
    endtask

    task automatic test_overflow();
        write_hdr(0, 33, 32'hA000_0000, 32'h0000_0001, 1'b0);
        push_read_exp(0, 127, 8'h21, 32'h0, 1'b1);
        push_read_exp(0, 124, 8'h22, 32'hA000_001F, 1'b0);
        for (int k = 0; k < 8; k++) begin
            push_read(0, $urandom_range(0, 127), $urandom_range(0, 255));
        end
        push_read(3, $urandom_range(0, 11), 8'h23);
        run_reads();
    endtask

    task automatic test_release();
        @(negedge clk);
        rel_valid = 1'b1;
        rel_slot  = 5'd3;
        @(negedge clk);
        rel_valid = 1'b0;
        mvld[3]   = 1'b0;
        vectors++;
        if (slot_vld[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL release_slot3: got %b required 0", slot_vld[3]);
        end
        push_read_exp(3, 0, 8'h31, 32'h0, 1'b1);
        run_reads();
        write_hdr(5, 2, 32'h0102_0304, 32'h1010_1010, 1'b1);
        vectors++;
        if (slot_vld[5] !== 1'b1) begin
            miscompares++;
            $display("FAIL rel_vs_commit_slot5: got %b required 1", slot_vld[5]);
        end
        push_read(5, 2, 8'h32);
        run_reads();
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        wr_valid = 1'b1; wr_sop = 1'b1; wr_last = 1'b0; wr_slot = 5'd9; wr_data = 32'h9999_0000;
        rd_valid = 1'b1; rd_slot = 5'd0; rd_off = 7'd0; rd_state = 8'h41;
        @(negedge clk);
        wr_sop = 1'b0; wr_data = 32'h9999_0001;
        rd_off = 7'd4;
        @(negedge clk);
        reset = 1'b0;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mvld = '0;
        wr_valid = 1'b1; wr_sop = 1'b1; wr_last = 1'b1; wr_slot = 5'd2; wr_data = 32'hDEAD_BEEF;
        mmem[2][0] = 32'hDEAD_BEEF;
        vectors++;
        if (slot_vld !== 32'h0) begin
            miscompares++;
            $display("FAIL slot_vld_after_reset: got %h required 0", slot_vld);
        end
        @(negedge clk);
        wr_valid = 1'b0; wr_sop = 1'b0; wr_last = 1'b0;
        mvld[2] = 1'b1;
        mlen[2] = 1;
        vectors++;
        if (slot_vld !== 32'h0000_0004) begin
            miscompares++;
            $display("FAIL sop_after_reset: got %h required 00000004", slot_vld);
        end
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flushed_out_valid: got %b required 0", out_valid);
            end
            @(negedge clk);
        end
        push_read_exp(2, 0, 8'h51, 32'hDEAD_BEEF, 1'b0);
        push_read(0, 0, 8'h52);
        push_read(9, 0, 8'h53);
        run_reads();
    endtask

    initial begin
        reset = 1'b0;
        wr_valid = 1'b0; wr_sop = 1'b0; wr_last = 1'b0; wr_slot = '0; wr_data = '0;
        rd_valid = 1'b0; rd_slot = '0; rd_off = '0; rd_state = '0;
        rel_valid = 1'b0; rel_slot = '0;
        mvld = '0;
        for (int s = 0; s < 32; s++) mlen[s] = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_errors();
        test_overflow();
        test_release();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
